// File: rtl/mem_dump_streamer_pkg.sv
// -----------------------------------------------------------------------------
// mem_dump_streamer_pkg
// Shared definitions for the memory dump streamer: data widths, the latency
// counter width, default parameter values, the FSM state encoding and small
// helpers that split a 32-bit memory word into its two halfwords.
// -----------------------------------------------------------------------------
package mem_dump_streamer_pkg;

  localparam int WORD_WIDTH        = 32;
  localparam int HALF_WIDTH        = 16;
  localparam int LAT_WIDTH         = 3;  // holds READ_LATENCY-1 for latencies 1..7
  localparam int DEF_ADDR_WIDTH    = 9;  // 512 words
  localparam int DEF_READ_LATENCY  = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_LO   = 3'd3,
    ST_HI   = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  // The loader places the even halfword in the low bits, the odd one above it.
  function automatic logic [HALF_WIDTH-1:0] lo_half(input logic [WORD_WIDTH-1:0] word);
    return word[HALF_WIDTH-1:0];
  endfunction

  function automatic logic [HALF_WIDTH-1:0] hi_half(input logic [WORD_WIDTH-1:0] word);
    return word[WORD_WIDTH-1:HALF_WIDTH];
  endfunction

endpackage

// File: rtl/mem_dump_streamer_if.sv
// -----------------------------------------------------------------------------
// mem_dump_streamer_if
// Bundles the two buses of the dump streamer:
//   memory read port : mem_addr, mem_rd_en (to memory), mem_rdata (from memory)
//   halfword stream  : hw_valid, hw_data, hw_last (to sink), hw_ready (from sink)
// Modports:
//   master - the streamer (drives address/strobe and the stream)
//   slave  - the memory + sink side (drives read data and ready)
// -----------------------------------------------------------------------------
interface mem_dump_streamer_if
  import mem_dump_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  hw_valid;
  logic [HALF_WIDTH-1:0] hw_data;
  logic                  hw_last;
  logic                  hw_ready;

  modport master (
    output mem_addr,
    output mem_rd_en,
    input  mem_rdata,
    output hw_valid,
    output hw_data,
    output hw_last,
    input  hw_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd_en,
    output mem_rdata,
    input  hw_valid,
    input  hw_data,
    input  hw_last,
    output hw_ready
  );

endinterface

// File: rtl/mem_dump_streamer.sv
// -----------------------------------------------------------------------------
// mem_dump_streamer
// Walks word_count memory words starting at base_addr and emits each word as
// two 16-bit halfwords, low half first, so the stream reproduces the halfword
// order the program loader packed into memory. One read is outstanding at a
// time; there is no prefetch. Addresses wrap modulo 2^ADDR_WIDTH.
//
// Parameters:
//   ADDR_WIDTH    word-address width
//   READ_LATENCY  cycles from mem_rd_en sampled to mem_rdata valid (1..7)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset; abandons any dump in flight
//   start_i       begin a dump; only honoured while idle
//   base_addr_i   first word address, latched on an accepted start
//   word_count_i  words to dump (0..2^ADDR_WIDTH), latched on an accepted start
//   busy_o        high from the cycle after an accepted start until done
//   done_o        one-cycle completion pulse (busy_o is already low with it)
//   bus           memory read port + halfword stream (master side)
//
// Every output is a register; the stream holds data/last stable while stalled.
// -----------------------------------------------------------------------------
module mem_dump_streamer
  import mem_dump_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  output logic                  busy_o,
  output logic                  done_o,
  mem_dump_streamer_if.master   bus
);

  localparam logic [LAT_WIDTH-1:0]  LAT_LOAD = LAT_WIDTH'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                state_q;
  logic [ADDR_WIDTH:0]   remaining_q;  // words not yet fully streamed
  logic [LAT_WIDTH-1:0]  lat_cnt_q;    // WAIT cycles left minus one
  logic [HALF_WIDTH-1:0] hi_half_q;    // odd halfword parked until LO is taken

  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;   // also serves as the current word address
  logic                  mem_rd_en_q;
  logic                  hw_valid_q;
  logic [HALF_WIDTH-1:0] hw_data_q;
  logic                  hw_last_q;

  logic [ADDR_WIDTH-1:0] next_addr_d;

  // Natural ADDR_WIDTH overflow gives the 0x1FF -> 0x000 wrap.
  assign next_addr_d = mem_addr_q + ADDR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      lat_cnt_q   <= '0;
      hi_half_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      hw_valid_q  <= 1'b0;
      hw_data_q   <= '0;
      hw_last_q   <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments; these two defaults make the
      // strobes single-cycle and are overridden below only where they fire.
      done_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            remaining_q <= word_count_i;
            if (word_count_i == '0) begin
              // Nothing to read: report completion without ever going busy
              // and without disturbing the last issued address.
              state_q <= ST_FIN;
            end else begin
              busy_q      <= 1'b1;
              mem_addr_q  <= base_addr_i;
              mem_rd_en_q <= 1'b1;
              state_q     <= ST_REQ;
            end
          end
        end

        ST_REQ: begin
          // The strobe is visible for exactly this cycle; start timing the read.
          lat_cnt_q <= LAT_LOAD;
          state_q   <= ST_WAIT;
        end

        ST_WAIT: begin
          if (lat_cnt_q == '0) begin
            // mem_rdata is only trusted on this exact cycle.
            hw_valid_q <= 1'b1;
            hw_data_q  <= lo_half(bus.mem_rdata);
            hi_half_q  <= hi_half(bus.mem_rdata);
            hw_last_q  <= 1'b0;
            state_q    <= ST_LO;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_WIDTH'(1);
          end
        end

        ST_LO: begin
          // Without ready everything holds, keeping the stalled beat stable.
          if (bus.hw_ready) begin
            hw_data_q <= hi_half_q;
            hw_last_q <= (remaining_q == CNT_ONE);
            state_q   <= ST_HI;
          end
        end

        ST_HI: begin
          if (bus.hw_ready) begin
            hw_valid_q  <= 1'b0;
            hw_last_q   <= 1'b0;
            remaining_q <= remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) begin
              state_q <= ST_FIN;
            end else begin
              mem_addr_q  <= next_addr_d;
              mem_rd_en_q <= 1'b1;
              state_q     <= ST_REQ;
            end
          end
        end

        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q     <= 1'b0;
          hw_valid_q <= 1'b0;
          hw_last_q  <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.hw_valid  = hw_valid_q;
  assign bus.hw_data   = hw_data_q;
  assign bus.hw_last   = hw_last_q;

endmodule

// File: tb/tb_mem_dump_streamer.sv
// -----------------------------------------------------------------------------
// tb_mem_dump_streamer
// Two streamer instances share the clock and reset: u_dut1 with a one-cycle
// memory and u_dut3 with a three-cycle memory. Memory models put random data
// on mem_rdata except exactly READ_LATENCY cycles after a strobe. Expected
// halfword streams are built directly from the memory contents.
// -----------------------------------------------------------------------------
module tb_mem_dump_streamer;
  import mem_dump_streamer_pkg::*;

  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;
  localparam int BOUND = 5000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ready;
  logic          start1, start3;
  logic [AW-1:0] base1, base3;
  logic [AW:0]   count1, count3;
  logic          busy1, done1, busy3, done3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_dump_streamer_if #(.ADDR_WIDTH(AW)) bus1 ();
  mem_dump_streamer_if #(.ADDR_WIDTH(AW)) bus3 ();

  assign bus1.hw_ready = ready;
  assign bus3.hw_ready = ready;

  mem_dump_streamer #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start1),
    .base_addr_i  (base1),
    .word_count_i (count1),
    .busy_o       (busy1),
    .done_o       (done1),
    .bus          (bus1)
  );

  mem_dump_streamer #(.ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start3),
    .base_addr_i  (base3),
    .word_count_i (count3),
    .busy_o       (busy3),
    .done_o       (done3),
    .bus          (bus3)
  );

  // Memory with garbage on the read bus whenever no read is landing.
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] pipe1;
  logic [WORD_WIDTH-1:0] pipe3 [3];

  always @(posedge clk) begin
    pipe1    <= bus1.mem_rd_en ? mem[bus1.mem_addr] : $urandom();
    pipe3[0] <= bus3.mem_rd_en ? mem[bus3.mem_addr] : $urandom();
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign bus1.mem_rdata = pipe1;
  assign bus3.mem_rdata = pipe3[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one dump on the chosen instance and checks it against the memory.
  // mode: 0 = sink always ready, 1 = ready toggles 1,0,1,0..., 2 = random.
  // repulse: pulse start again (different base) four cycles in.
  task automatic run_dump(input string tag, input int which, input int base,
                          input int count, input int mode, input bit repulse,
                          output int first_valid, output int done_at);
    logic [15:0]   exp_q[$];
    logic [15:0]   got_q[$];
    int            last_pos[$];
    int            addr_q[$];
    logic [31:0]   w;
    int            busy_err;
    int            done_cnt;
    bit            prev_stall;
    logic [15:0]   prev_d;
    logic          prev_l;
    logic          v, l, rd, bz, dn, st, exp_busy;
    logic [15:0]   d;
    logic [AW-1:0] a;

    busy_err    = 0;
    done_cnt    = 0;
    prev_stall  = 1'b0;
    prev_d      = '0;
    prev_l      = 1'b0;
    first_valid = -1;
    done_at     = -1;

    for (int i = 0; i < count; i++) begin
      w = mem[(base + i) % DEPTH];
      exp_q.push_back(w[15:0]);
      exp_q.push_back(w[31:16]);
    end

    for (int cyc = 0; cyc < BOUND; cyc++) begin
      @(negedge clk);
      st = (cyc == 0) || (repulse && cyc == 4);
      if (which == 3) begin
        start3 = st;
        if (st) begin
          base3  = (cyc == 0) ? AW'(base) : AW'(base ^ 'h0AA);
          count3 = (AW+1)'(count);
        end
        v = bus3.hw_valid; d = bus3.hw_data; l = bus3.hw_last;
        rd = bus3.mem_rd_en; a = bus3.mem_addr; bz = busy3; dn = done3;
      end else begin
        start1 = st;
        if (st) begin
          base1  = (cyc == 0) ? AW'(base) : AW'(base ^ 'h0AA);
          count1 = (AW+1)'(count);
        end
        v = bus1.hw_valid; d = bus1.hw_data; l = bus1.hw_last;
        rd = bus1.mem_rd_en; a = bus1.mem_addr; bz = busy1; dn = done1;
      end

      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2 == 0);
        default: ready = ($urandom_range(0, 3) != 0);
      endcase

      if (prev_stall) begin
        check($sformatf("%s stall_valid@%0d", tag, cyc), 32'(v), 32'd1);
        check($sformatf("%s stall_data@%0d", tag, cyc), 32'(d), 32'(prev_d));
        check($sformatf("%s stall_last@%0d", tag, cyc), 32'(l), 32'(prev_l));
      end

      if (v && ready) begin
        got_q.push_back(d);
        if (l) last_pos.push_back(got_q.size() - 1);
      end
      prev_stall = v && !ready;
      prev_d     = d;
      prev_l     = l;

      if (rd) addr_q.push_back(int'(a));
      if (v && first_valid < 0) first_valid = cyc;
      if (dn) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end

      exp_busy = (count != 0) && (cyc >= 1) && (done_at < 0);
      if (bz !== exp_busy) busy_err++;

      if (done_at >= 0 && cyc >= done_at + 3) break;
    end
    start1 = 1'b0;
    start3 = 1'b0;
    ready  = 1'b1;

    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    check({tag, " busy_profile_errors"}, 32'(busy_err), 32'd0);
    check({tag, " halfword_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s hw[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, " last_count"}, 32'(last_pos.size()), (count != 0) ? 32'd1 : 32'd0);
    if (last_pos.size() > 0)
      check({tag, " last_position"}, 32'(last_pos[0]), 32'(2 * count - 1));
    check({tag, " read_count"}, 32'(addr_q.size()), 32'(count));
    for (int i = 0; i < addr_q.size() && i < count; i++)
      check($sformatf("%s rd_addr[%0d]", tag, i), 32'(addr_q[i]), 32'((base + i) % DEPTH));
  endtask

  initial begin
    int fv, da, xfers;
    bit hit;

    rst_n  = 1'b0;
    ready  = 1'b1;
    start1 = 1'b0; base1 = '0; count1 = '0;
    start3 = 1'b0; base3 = '0; count3 = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy",      32'(busy1),          32'd0);
    check("rst done",      32'(done1),          32'd0);
    check("rst rd_en",     32'(bus1.mem_rd_en), 32'd0);
    check("rst addr",      32'(bus1.mem_addr),  32'd0);
    check("rst hw_valid",  32'(bus1.hw_valid),  32'd0);
    check("rst hw_data",   32'(bus1.hw_data),   32'd0);
    check("rst hw_last",   32'(bus1.hw_last),   32'd0);
    check("rst3 hw_valid", 32'(bus3.hw_valid),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word dump from address 0: ABCD,1234,0011,00FF
    mem[0] = 32'h1234ABCD;
    mem[1] = 32'h00FF0011;
    run_dump("t1", 1, 0, 2, 0, 1'b0, fv, da);
    check("t1 first_valid_cycle", 32'(fv), 32'd3);
    check("t1 done_cycle",        32'(da), 32'd10);

    // Zero-length dump: no reads, no stream, done two cycles after start
    run_dump("t2", 1, 5, 0, 0, 1'b0, fv, da);
    check("t2 done_cycle",  32'(da), 32'd2);
    check("t2 no_hw_valid", 32'(fv), 32'hFFFF_FFFF);

    // Back-pressure alternating every cycle
    run_dump("t3", 1, 'h40, 3, 1, 1'b0, fv, da);

    // Address wrap at the top of memory
    run_dump("t4", 1, 'h1FE, 3, 0, 1'b0, fv, da);
    check("t4 done_cycle", 32'(da), 32'd14);

    // Three-cycle read latency
    run_dump("t5", 3, 'h10, 1, 0, 1'b0, fv, da);
    check("t5 first_valid_cycle", 32'(fv), 32'd5);
    check("t5 done_cycle",        32'(da), 32'd8);

    // Reset during the high half of word 2 of 4, then a clean restart
    hit   = 1'b0;
    xfers = 0;
    @(negedge clk);
    start1 = 1'b1; base1 = AW'('h20); count1 = (AW+1)'(4);
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (bus1.hw_valid && xfers == 3) begin
        hit = 1'b1;
        break;
      end
      if (bus1.hw_valid && ready) xfers++;
    end
    check("t6 reached_word2_hi", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6 hw_valid", 32'(bus1.hw_valid),  32'd0);
    check("t6 hw_data",  32'(bus1.hw_data),   32'd0);
    check("t6 hw_last",  32'(bus1.hw_last),   32'd0);
    check("t6 busy",     32'(busy1),          32'd0);
    check("t6 rd_en",    32'(bus1.mem_rd_en), 32'd0);
    check("t6 addr",     32'(bus1.mem_addr),  32'd0);
    @(negedge clk);
    check("t6 no_done",  32'(done1),          32'd0);
    rst_n = 1'b1;
    run_dump("t6r", 1, 'h20, 4, 0, 1'b0, fv, da);

    // Start re-pulsed while busy is ignored
    run_dump("t7", 1, 'h80, 3, 0, 1'b1, fv, da);

    // Randomized dumps with random back-pressure on both latencies
    for (int k = 0; k < 4; k++)
      run_dump($sformatf("rnd%0d", k), (k % 2 == 0) ? 1 : 3,
               int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 8)),
               2, 1'b0, fv, da);

    // Whole memory once, starting mid-array so the wrap is crossed
    run_dump("full", 1, 'h123, DEPTH, 0, 1'b0, fv, da);
    check("full done_cycle", 32'(da), 32'(1 + DEPTH * 4 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
